// File: rtl/cu_pkg.sv
// Shared Control Unit definitions: sequencer state encoding, execution unit
// indices and the default unit count used by fsm_dispatch and its neighbours.
package cu_pkg;

  // Number of execution sub-FSMs hanging off the dispatcher by default.
  localparam int N_UNITS_DEFAULT = 6;

  // Bit positions of each execution unit in the one-hot request/start/done vectors.
  localparam int UNIT_ALU         = 0;
  localparam int UNIT_BRANCH_JUMP = 1;
  localparam int UNIT_LOAD_STORE  = 2;
  localparam int UNIT_FP          = 3;
  localparam int UNIT_MUL_DIV     = 4;
  localparam int UNIT_SYSTEM      = 5;

  // Top-level sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_LOAD_IR  = 3'd2,
    ST_DECODE   = 3'd3,
    ST_DISPATCH = 3'd4,
    ST_WAIT     = 3'd5,
    ST_HALT     = 3'd6
  } cu_state_e;

  // Build a one-hot unit mask from a unit index.
  function automatic logic [N_UNITS_DEFAULT-1:0] unit_mask(input int idx);
    logic [N_UNITS_DEFAULT-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/fsm_dispatch_onehot_check.sv
// onehot_check: purely combinational test that exactly one bit of the
// request vector is set. Shared with the opdecoder bench.
module onehot_check #(
  parameter int WIDTH = cu_pkg::N_UNITS_DEFAULT
) (
  input  logic [WIDTH-1:0] unit_req,
  output logic             is_onehot
);

  // A vector is one-hot when it is non-zero and clearing its lowest set bit leaves zero.
  always_comb begin
    is_onehot = (unit_req != '0) && ((unit_req & (unit_req - WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/fsm_dispatch.sv
// fsm_dispatch: top-level multicycle Control Unit sequencer. Fetches an
// instruction, loads the IR, lets the opdecoder settle for one cycle, then
// starts exactly one execution sub-FSM and waits for its done. Counts retired
// instructions and halts permanently on an illegal (non one-hot) decode.
//
// Optional build macro DISPATCH_WATCHDOG_EN adds a WAIT-state watchdog that
// traps to HALT after TIMEOUT cycles without the selected done. Without it the
// timeout flag is constant 0 and WAIT may last indefinitely.
module fsm_dispatch
  import cu_pkg::*;
#(
  parameter int N_UNITS = N_UNITS_DEFAULT,
  parameter int TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic               imem_req,
  input  logic               imem_ready,
  output logic               load_ir,
  input  logic [N_UNITS-1:0] unit_req,
  output logic [N_UNITS-1:0] start,
  input  logic [N_UNITS-1:0] done,
  output logic               busy,
  output logic               halted,
  output logic               illegal,
  output logic               timeout,
  output logic [63:0]        instret
);

  cu_state_e          state_q, state_d;
  logic [N_UNITS-1:0] sel_q, sel_d;
  logic [63:0]        instret_q, instret_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;
  logic               req_onehot;
  logic               sel_done;

  onehot_check #(
    .WIDTH (N_UNITS)
  ) u_onehot_check (
    .unit_req  (unit_req),
    .is_onehot (req_onehot)
  );

  // Only the done bit of the unit we actually started can end WAIT.
  always_comb begin
    sel_done = |(done & sel_q);
  end

`ifdef DISPATCH_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_expire;

  // Watchdog counter: cleared as WAIT is entered, counts every WAIT cycle.
  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    wd_expire = 1'b0;
    if (state_q == ST_DISPATCH) begin
      wd_cnt_d = '0;
    end else if (state_q == ST_WAIT) begin
      wd_cnt_d  = wd_cnt_q + WD_W'(1);
      wd_expire = (wd_cnt_d == WD_W'(TIMEOUT));
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`endif

  // Next-state, datapath-register updates and Moore outputs; defaults first.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    instret_d = instret_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;

    imem_req  = 1'b0;
    load_ir   = 1'b0;
    start     = '0;
    busy      = 1'b1;
    halted    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (run) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          state_d = ST_LOAD_IR;
        end
      end

      ST_LOAD_IR: begin
        load_ir = 1'b1;
        state_d = ST_DECODE;
      end

      ST_DECODE: begin
        if (req_onehot) begin
          sel_d   = unit_req;
          state_d = ST_DISPATCH;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end
      end

      ST_DISPATCH: begin
        start   = sel_q;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (sel_done) begin
          instret_d = instret_q + 64'd1;
          state_d   = run ? ST_FETCH : ST_IDLE;
        end
`ifdef DISPATCH_WATCHDOG_EN
        else if (wd_expire) begin
          timeout_d = 1'b1;
          state_d   = ST_HALT;
        end
`endif
      end

      ST_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end

      default: begin
        state_d = ST_HALT;
        busy    = 1'b0;
      end
    endcase
  end

  // State and sequencer registers; reset drops every Moore output immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Sticky status flags and the retired-instruction counter.
  always_comb begin
    illegal = illegal_q;
    timeout = timeout_q;
    instret = instret_q;
  end

endmodule

// File: tb/tb_fsm_dispatch.sv
// tb_fsm_dispatch: directed, self-checking bench for fsm_dispatch. Inputs are
// driven 1 time unit after each rising edge and outputs sampled there too.
// Build with DISPATCH_WATCHDOG_EN to include the watchdog scenarios.
module tb_fsm_dispatch;

  localparam int NU = 6;

  logic          clk;
  logic          reset;
  logic          run;
  logic          imem_req;
  logic          imem_ready;
  logic          load_ir;
  logic [NU-1:0] unit_req;
  logic [NU-1:0] start;
  logic [NU-1:0] done;
  logic          busy;
  logic          halted;
  logic          illegal;
  logic          timeout;
  logic [63:0]   instret;

  int compareCount = 0;
  int mismatchCount = 0;

  fsm_dispatch #(
    .N_UNITS (NU),
`ifdef DISPATCH_WATCHDOG_EN
    .TIMEOUT (8)
`else
    .TIMEOUT (32)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .imem_req   (imem_req),
    .imem_ready (imem_ready),
    .load_ir    (load_ir),
    .unit_req   (unit_req),
    .start      (start),
    .done       (done),
    .busy       (busy),
    .halted     (halted),
    .illegal    (illegal),
    .timeout    (timeout),
    .instret    (instret)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and count it.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the level inputs in one go.
  task automatic applyStimulus(input logic r, input logic rdy, input logic [NU-1:0] req, input logic [NU-1:0] dn);
    run        = r;
    imem_ready = rdy;
    unit_req   = req;
    done       = dn;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0);
    tick();
    tick();

    // Reset state.
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_illegal", illegal, 0);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_instret", instret, 0);
    checkOutput("rst_start", start, 0);
    checkOutput("rst_imem_req", imem_req, 0);
    reset = 1'b0;
    tick();
    checkOutput("idle_hold_busy", busy, 0);

    // Basic instruction on unit 1, done three cycles after start.
    applyStimulus(1'b1, 1'b1, 6'b000010, '0);
    tick();
    checkOutput("t1_fetch_req", imem_req, 1);
    checkOutput("t1_fetch_busy", busy, 1);
    tick();
    checkOutput("t1_loadir", load_ir, 1);
    checkOutput("t1_loadir_req", imem_req, 0);
    tick();
    checkOutput("t1_decode_loadir", load_ir, 0);
    checkOutput("t1_decode_start", start, 0);
    tick();
    checkOutput("t1_dispatch_start", start, 6'b000010);
    tick();
    checkOutput("t1_wait1_start", start, 0);
    tick();
    tick();
    done = 6'b000010;
    tick();
    done = '0;
    checkOutput("t1_refetch_req", imem_req, 1);
    checkOutput("t1_instret", instret, 1);

    // Memory latency: imem_ready low for four FETCH cycles.
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t2_req_hold%0d", i), imem_req, 1);
      checkOutput($sformatf("t2_noload%0d", i), load_ir, 0);
      if (i < 3) tick();
    end
    imem_ready = 1'b1;
    tick();
    checkOutput("t2_loadir", load_ir, 1);
    tick();
    checkOutput("t2_loadir_once", load_ir, 0);
    tick();
    checkOutput("t2_dispatch_start", start, 6'b000010);
    tick();

    // Foreign done[3] in WAIT is ignored; done[1] two cycles later retires.
    done = 6'b001000;
    tick();
    done = '0;
    checkOutput("t4_still_wait_busy", busy, 1);
    checkOutput("t4_still_wait_req", imem_req, 0);
    checkOutput("t4_no_retire", instret, 1);
    tick();
    checkOutput("t4_wait3_req", imem_req, 0);
    done = 6'b000010;
    tick();
    done = '0;
    checkOutput("t4_refetch_req", imem_req, 1);
    checkOutput("t4_instret", instret, 2);

    // run drops mid-instruction: the instruction completes, then IDLE.
    tick();
    tick();
    tick();
    checkOutput("t5_dispatch_start", start, 6'b000010);
    tick();
    run = 1'b0;
    tick();
    checkOutput("t5_wait_busy", busy, 1);
    done = 6'b000010;
    tick();
    done = '0;
    checkOutput("t5_idle_busy", busy, 0);
    checkOutput("t5_idle_req", imem_req, 0);
    checkOutput("t5_instret", instret, 3);
    tick();
    checkOutput("t5_idle_stay", busy, 0);
    run = 1'b1;
    tick();
    checkOutput("t5_resume_req", imem_req, 1);

    // Asynchronous reset while start is pulsing.
    tick();
    tick();
    tick();
    checkOutput("t6_dispatch_start", start, 6'b000010);
    #1 reset = 1'b1;
    #1;
    checkOutput("t6_async_start", start, 0);
    checkOutput("t6_async_instret", instret, 0);
    checkOutput("t6_async_busy", busy, 0);
    tick();
    reset = 1'b0;

    // Illegal decode with two bits set: halts and never starts a unit.
    applyStimulus(1'b1, 1'b1, 6'b000110, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("t3_nostart%0d", i), start, 0);
    end
    tick();
    checkOutput("t3_illegal", illegal, 1);
    checkOutput("t3_halted", halted, 1);
    checkOutput("t3_busy", busy, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("t3_stay_halted%0d", i), halted, 1);
      checkOutput($sformatf("t3_stay_nostart%0d", i), start, 0);
      checkOutput($sformatf("t3_stay_noreq%0d", i), imem_req, 0);
    end

    // Illegal decode with no bit set.
    doReset();
    checkOutput("t3z_cleared", illegal, 0);
    applyStimulus(1'b1, 1'b1, 6'b000000, '0);
    tick();
    tick();
    tick();
    tick();
    checkOutput("t3z_illegal", illegal, 1);
    checkOutput("t3z_halted", halted, 1);

    // Highest unit index dispatches correctly.
    doReset();
    applyStimulus(1'b1, 1'b1, 6'b100000, '0);
    tick();
    tick();
    tick();
    tick();
    checkOutput("t7_start_top", start, 6'b100000);
    tick();
    done = 6'b100000;
    tick();
    done = '0;
    checkOutput("t7_instret", instret, 1);
    checkOutput("t7_refetch", imem_req, 1);

`ifdef DISPATCH_WATCHDOG_EN
    // Watchdog trap exactly eight cycles after entering WAIT.
    doReset();
    applyStimulus(1'b1, 1'b1, 6'b000001, '0);
    tick();
    tick();
    tick();
    tick();
    tick();
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("wd_not_yet%0d", i), halted, 0);
      tick();
    end
    checkOutput("wd_last_wait", halted, 0);
    tick();
    checkOutput("wd_timeout", timeout, 1);
    checkOutput("wd_halted", halted, 1);
    checkOutput("wd_no_retire", instret, 0);

    // done on the expiring cycle wins over the trap.
    doReset();
    applyStimulus(1'b1, 1'b1, 6'b000001, '0);
    tick();
    tick();
    tick();
    tick();
    tick();
    for (int i = 0; i < 7; i++) tick();
    done = 6'b000001;
    tick();
    done = '0;
    checkOutput("wd_race_timeout", timeout, 0);
    checkOutput("wd_race_instret", instret, 1);
    checkOutput("wd_race_fetch", imem_req, 1);
`else
    // Without the watchdog, WAIT outlasts any timeout.
    doReset();
    applyStimulus(1'b1, 1'b1, 6'b000001, '0);
    for (int i = 0; i < 45; i++) tick();
    checkOutput("nowd_still_busy", busy, 1);
    checkOutput("nowd_timeout", timeout, 0);
    done = 6'b000001;
    tick();
    done = '0;
    checkOutput("nowd_instret", instret, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
